alu_cmp_pipe: RTL and testbench
===============================

# alu_cmp_pipe

Parametrised, pipelined compare/branch-condition unit for the ALU. It is the successor to the single-mode "less-or-equal-zero" comparator. It evaluates one of eight compare modes on operands of configurable width, in signed or unsigned form. Results pass through a valid/ready-handshaked pipeline of 1 or 2 stages. The unit also keeps a saturating count of true conditions, which the branch unit and performance monitors use.

## Interface
Parameters:
- WIDTH, 32: operand and result width; must be 2 or more.
- STAGES, 1: pipeline depth; only 1 or 2 is legal.
- CNT_W, 16: width of the taken-condition counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; used only by EQ, NE and LT.
- mode  in  3  compare mode; encodings are in the package.
- is_signed  in  1  1 selects two's-complement compare; 0 selects unsigned.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result beat.
- s  out  WIDTH  result; equals {WIDTH-1 zeros, cond}.
- z  out  1  1 when s == 0.
- v  out  1  illegal mode flag; 1 when mode == 7.
- n  out  1  always 0; kept for flag-bus compatibility.
- cnt_clr  in  1  synchronous clear of taken_cnt.
- taken_cnt  out  CNT_W  count of delivered beats with cond = 1; saturates.

## Operation
Condition `cond` per mode:
- 0 EQ: a == b.
- 1 NE: a != b.
- 2 LEZ:
  - signed: a == 0 or a[WIDTH-1] = 1.
  - unsigned: a == 0.
- 3 GTZ: the inverse of LEZ, in the same signedness.
- 4 LTZ:
  - signed: a[WIDTH-1].
  - unsigned: always 0.
- 5 GEZ: the inverse of LTZ.
- 6 LT: a < b, signed or unsigned as selected.
- 7 reserved: cond = 0 and v = 1.

Flags and counter:
- z = ~cond. v is 1 only for mode 7. n = 0.
- taken_cnt increments by 1 when out_valid & out_ready & cond = 1.
- taken_cnt holds at all-ones once it saturates; it does not wrap.
- If cnt_clr is asserted in the same cycle as a counted handshake, the clear wins and taken_cnt becomes 0.

## Timing
- Pipeline advance condition: adv = ~out_valid | out_ready. in_ready = adv, combinationally.
- An input beat is accepted when in_valid & in_ready.
- STAGES = 1:
  - cond is computed combinationally from the inputs and registered.
  - Latency is 1 cycle from acceptance to out_valid.
- STAGES = 2:
  - Stage 1 registers a, b, mode and is_signed.
  - Stage 2 computes cond from the stage-1 registers and registers the result.
  - Latency is 2 cycles.
- When adv = 1, every stage loads from the stage before it. An invalid beat loads as a bubble, clearing that stage's valid.
- When adv = 0, all stages hold. Bubbles are not collapsed while stalled.
- Throughput is 1 beat per cycle while out_ready stays high.
- Outputs s, z, v and n change only on a cycle where a result stage loads a valid beat. While out_valid = 0 they hold their last values.
- Reset values: out_valid 0, all internal valids 0, s 0, z 0, v 0, n 0, taken_cnt 0.
- Reset asserted mid-operation drops every in-flight beat. in_ready is 1 in the first cycle after reset deasserts.

## Structure
- Package alu_cmp_pkg holds:
  - mode localparams CMP_EQ through CMP_RSV (values 0 to 7);
  - a typedef for the 3-bit mode field.
- Sub-module alu_cmp_core: purely combinational. Inputs are a, b, mode and is_signed; outputs are cond and illegal. It is instantiated once, and its position depends on STAGES.
- The top level holds the stage registers, the handshake logic and the counter.

## Test plan
- Signed LEZ, WIDTH 32, STAGES 1, out_ready = 1. Drive a = 0, then 0xFFFFFFFF, then 5. Required: s = 1, 1, 0 and z = 0, 0, 1, each one cycle after acceptance.
- Unsigned LEZ and LTZ with a = 0x80000000. Required: both s = 0. Unsigned GEZ with the same a: s = 1.
- STAGES 2, 10 back-to-back LT beats with out_ready = 1. Then hold out_ready = 0 for 3 cycles in the middle of the stream. Required:
  - first out_valid 2 cycles after the first acceptance;
  - in_ready = 0 while stalled;
  - no beat lost or duplicated;
  - results delivered in order.
- Mode 7 with any operands. Required: s = 0, z = 1, v = 1, taken_cnt unchanged.
- CNT_W 4, 20 EQ beats with a = b. Required: taken_cnt saturates at 15. Then pulse cnt_clr in the same cycle as a true handshake. Required: taken_cnt = 0.
- Assert reset with 2 beats in flight. Required:
  - out_valid = 0 and taken_cnt = 0 immediately;
  - in_ready = 1 in the first cycle after reset;
  - neither stale beat is ever emitted.

Source files
------------

// File: rtl/alu_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmp_pkg
// Description : Shared definitions for the pipelined compare / branch-condition
//               unit: compare-mode encodings and the mode field type.
// Contents    : cmp_mode_t          3-bit compare mode field
//               CMP_EQ .. CMP_RSV   mode encodings 0..7
//               CMP_MODE_W          width of the mode field
// Revision    : 1.0 - initial release
// ============================================================================
package alu_cmp_pkg;

    localparam int CMP_MODE_W = 3;

    typedef logic [CMP_MODE_W-1:0] cmp_mode_t;

    // Compare modes. Only EQ, NE and LT look at operand B.
    localparam cmp_mode_t CMP_EQ  = 3'd0;  // a == b
    localparam cmp_mode_t CMP_NE  = 3'd1;  // a != b
    localparam cmp_mode_t CMP_LEZ = 3'd2;  // a <= 0
    localparam cmp_mode_t CMP_GTZ = 3'd3;  // a >  0
    localparam cmp_mode_t CMP_LTZ = 3'd4;  // a <  0
    localparam cmp_mode_t CMP_GEZ = 3'd5;  // a >= 0
    localparam cmp_mode_t CMP_LT  = 3'd6;  // a <  b
    localparam cmp_mode_t CMP_RSV = 3'd7;  // reserved, flagged as illegal

endpackage
`default_nettype wire

// File: rtl/alu_cmp_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmp_core
// Description : Purely combinational compare evaluator. Produces the branch
//               condition for one of eight compare modes, signed or unsigned.
// Ports       : a, b       in   WIDTH  operands (b used by EQ, NE, LT only)
//               mode       in   3      compare mode (alu_cmp_pkg encodings)
//               is_signed  in   1      1 = two's-complement, 0 = unsigned
//               cond       out  1      evaluated condition
//               illegal    out  1      reserved mode selected
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmp_core
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  cmp_mode_t        mode,
    input  logic             is_signed,
    output logic             cond,
    output logic             illegal
);

    logic a_zero;
    logic a_neg;
    logic a_lez;
    logic a_lt_b;

    // In unsigned form nothing is negative, so LEZ collapses to a == 0 and
    // LTZ is constant false; both fall out of gating the sign bit.
    assign a_zero = (a == '0);
    assign a_neg  = is_signed & a[WIDTH-1];
    assign a_lez  = a_zero | a_neg;
    assign a_lt_b = is_signed ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (mode)
            CMP_EQ:  cond = (a == b);
            CMP_NE:  cond = (a != b);
            CMP_LEZ: cond = a_lez;
            CMP_GTZ: cond = ~a_lez;
            CMP_LTZ: cond = a_neg;
            CMP_GEZ: cond = ~a_neg;
            CMP_LT:  cond = a_lt_b;
            default: begin
                cond    = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmp_pipe
// Description : Pipelined compare / branch-condition unit with valid/ready
//               handshake (1 or 2 stages) and a saturating count of
//               delivered true conditions.
// Ports       : clk        in   1      rising-edge clock
//               reset      in   1      asynchronous active-high reset
//               in_valid   in   1      operand beat valid
//               in_ready   out  1      beat can be accepted this cycle
//               a, b       in   WIDTH  operands
//               mode       in   3      compare mode
//               is_signed  in   1      signed / unsigned compare select
//               out_valid  out  1      result beat valid
//               out_ready  in   1      consumer takes the result beat
//               s          out  WIDTH  {WIDTH-1 zeros, cond}
//               z          out  1      s == 0
//               v          out  1      reserved mode flag
//               n          out  1      constant 0 (flag-bus compatibility)
//               cnt_clr    in   1      synchronous clear of taken_cnt
//               taken_cnt  out  CNT_W  saturating count of true results
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmp_pipe
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH  = 32,   // operand width, 2 or more
    parameter int STAGES = 1,    // pipeline depth, 1 or 2
    parameter int CNT_W  = 16    // taken-condition counter width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  cmp_mode_t        mode,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             v,
    output logic             n,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // The whole pipe moves in lock-step: every stage advances when the
    // result stage is empty or being drained. No bubble collapsing.
    logic adv;

    // Operands seen by the compare core and the valid bit of the beat they
    // belong to; their source depends on the pipeline depth.
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    cmp_mode_t        core_mode;
    logic             core_signed;
    logic             head_valid;

    logic             cond;
    logic             illegal;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign n        = 1'b0;

    generate
        if (STAGES == 2) begin : g_two_stage
            logic             s1_valid;
            logic [WIDTH-1:0] s1_a;
            logic [WIDTH-1:0] s1_b;
            cmp_mode_t        s1_mode;
            logic             s1_signed;

            // Operand register stage. Data is only captured for valid beats;
            // a bubble just clears the valid bit.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_valid  <= 1'b0;
                    s1_a      <= '0;
                    s1_b      <= '0;
                    s1_mode   <= CMP_EQ;
                    s1_signed <= 1'b0;
                end else if (adv) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_a      <= a;
                        s1_b      <= b;
                        s1_mode   <= mode;
                        s1_signed <= is_signed;
                    end
                end
            end

            assign core_a      = s1_a;
            assign core_b      = s1_b;
            assign core_mode   = s1_mode;
            assign core_signed = s1_signed;
            assign head_valid  = s1_valid;
        end else begin : g_one_stage
            assign core_a      = a;
            assign core_b      = b;
            assign core_mode   = mode;
            assign core_signed = is_signed;
            assign head_valid  = in_valid;
        end
    endgenerate

    alu_cmp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (core_a),
        .b         (core_b),
        .mode      (core_mode),
        .is_signed (core_signed),
        .cond      (cond),
        .illegal   (illegal)
    );

    // Result stage. Flags only move when a valid beat lands, so a consumer
    // looking at s/z/v between beats sees the last delivered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            s         <= '0;
            z         <= 1'b0;
            v         <= 1'b0;
        end else if (adv) begin
            out_valid <= head_valid;
            if (head_valid) begin
                s <= {{(WIDTH-1){1'b0}}, cond};
                z <= ~cond;
                v <= illegal;
            end
        end
    end

    // Counts beats actually delivered with a true condition. Clear has
    // priority over a coincident count; the count sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt <= '0;
        end else if (cnt_clr) begin
            taken_cnt <= '0;
        end else if (out_valid && out_ready && s[0] && (taken_cnt != CNT_MAX)) begin
            taken_cnt <= taken_cnt + CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmp_pipe
// Description : Self-checking bench. Two instances share one stimulus:
//               index 0 = 1 stage with a 4-bit counter,
//               index 1 = 2 stages with a 16-bit counter.
//               A behavioural model (arithmetic compare, result queues,
//               accept history for latency, counter) predicts all outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmp_pipe;
    import alu_cmp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  mode;
    logic        is_signed;
    logic        out_ready;
    logic        cnt_clr;

    logic [1:0]  rdy;
    logic [1:0]  ov;
    logic [1:0]  z;
    logic [1:0]  v;
    logic [1:0]  n;
    logic [31:0] s_o [2];
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    always #5 clk = ~clk;

    alu_cmp_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .mode(mode), .is_signed(is_signed),
        .out_valid(ov[0]), .out_ready(out_ready), .s(s_o[0]),
        .z(z[0]), .v(v[0]), .n(n[0]), .cnt_clr(cnt_clr), .taken_cnt(cnt_a)
    );

    alu_cmp_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a), .b(b), .mode(mode), .is_signed(is_signed),
        .out_valid(ov[1]), .out_ready(out_ready), .s(s_o[1]),
        .z(z[1]), .v(v[1]), .n(n[1]), .cnt_clr(cnt_clr), .taken_cnt(cnt_b)
    );

    // ---------------- bookkeeping and model state ----------------
    int nvec = 0;
    int nerr = 0;

    int          st   [2] = '{1, 2};
    int          cmax [2] = '{15, 65535};
    int          mcnt [2];
    logic [3:0]  ah   [2];   // accept history, bit 0 = most recent edge
    int          clean[2];   // consecutive edges with out_ready = 1
    logic        accd [2];   // beat accepted at the last edge
    logic [1:0]  q0 [$];     // {illegal, cond} per accepted beat, dut 0
    logic [1:0]  q1 [$];     // same, dut 1

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare rules expressed as arithmetic on the operand's numeric value.
    function automatic logic [1:0] ref_res(input logic [31:0] ra, input logic [31:0] rb,
                                           input logic [2:0] rm, input logic sg);
        longint va, vb;
        logic   c;
        va = longint'(ra);
        vb = longint'(rb);
        if (sg && ra[31]) va = va - 64'sh1_0000_0000;
        if (sg && rb[31]) vb = vb - 64'sh1_0000_0000;
        case (rm)
            3'd0:    c = (va == vb);
            3'd1:    c = (va != vb);
            3'd2:    c = (va <= 0);
            3'd3:    c = (va > 0);
            3'd4:    c = (va < 0);
            3'd5:    c = (va >= 0);
            3'd6:    c = (va < vb);
            default: c = 1'b0;
        endcase
        return {(rm == 3'd7), c};
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic vld, input logic [31:0] da, input logic [31:0] db,
                         input logic [2:0] dm, input logic sg);
        in_valid  = vld;
        a         = da;
        b         = db;
        mode      = dm;
        is_signed = sg;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]  = 0;
            ah[k]    = '0;
            clean[k] = 8;
            accd[k]  = 1'b0;
        end
    endtask

    // One clock: sample handshakes before the edge, update the model,
    // then check registered outputs just after the edge.
    task automatic tick();
        logic       hs;
        logic       acc;
        logic [1:0] e;
        logic [31:0] obs;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            hs  = ov[k] & out_ready;
            acc = in_valid & rdy[k];
            e   = 2'b00;
            check($sformatf("in_ready%0d", k), {31'b0, rdy[k]}, {31'b0, out_ready | ~ov[k]});
            if (hs) begin
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("spurious_beat%0d", k), 32'd1, 32'd0);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("s%0d", k), s_o[k], {31'b0, e[0]});
                    check($sformatf("z%0d", k), {31'b0, z[k]}, {31'b0, ~e[0]});
                    check($sformatf("v%0d", k), {31'b0, v[k]}, {31'b0, e[1]});
                end
            end
            if (cnt_clr) mcnt[k] = 0;
            else if (hs && e[0] && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
            if (acc) begin
                if (k == 0) q0.push_back(ref_res(a, b, mode, is_signed));
                else        q1.push_back(ref_res(a, b, mode, is_signed));
            end
            ah[k]    = {ah[k][2:0], acc};
            clean[k] = out_ready ? clean[k] + 1 : 0;
            accd[k]  = acc;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            obs = (k == 0) ? {28'b0, cnt_a} : {16'b0, cnt_b};
            check($sformatf("taken_cnt%0d", k), obs, mcnt[k]);
            check($sformatf("n%0d", k), {31'b0, n[k]}, 32'd0);
            if (clean[k] >= st[k])
                check($sformatf("out_valid%0d", k), {31'b0, ov[k]}, {31'b0, ah[k][st[k]-1]});
        end
    endtask

    task automatic drain(input int cycles);
        drive(1'b0, '0, '0, CMP_EQ, 1'b0);
        out_ready = 1'b1;
        repeat (cycles) tick();
        check("lost_beats0", q0.size(), 32'd0);
        check("lost_beats1", q1.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] la [10];
    logic [31:0] lb [10];
    logic        ls [10];
    logic [31:0] tmp;
    int          saved;

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        drive(1'b0, '0, '0, CMP_EQ, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_out_valid%0d", k), {31'b0, ov[k]}, 32'd0);
            check($sformatf("rst_s%0d", k), s_o[k], 32'd0);
            check($sformatf("rst_zv%0d", k), {30'b0, z[k], v[k]}, 32'd0);
        end
        check("rst_cnt", {cnt_b, 12'b0, cnt_a}, 32'd0);
        reset = 1'b0;

        // Signed LEZ: 0, -1, 5
        drive(1'b1, 32'd0, 32'd0, CMP_LEZ, 1'b1); tick();
        check("lez_zero_s", s_o[0], 32'd1);  check("lez_zero_z", {31'b0, z[0]}, 32'd0);
        drive(1'b1, 32'hFFFF_FFFF, 32'd0, CMP_LEZ, 1'b1); tick();
        check("lez_neg_s", s_o[0], 32'd1);   check("lez_neg_z", {31'b0, z[0]}, 32'd0);
        drive(1'b1, 32'd5, 32'd0, CMP_LEZ, 1'b1); tick();
        check("lez_pos_s", s_o[0], 32'd0);   check("lez_pos_z", {31'b0, z[0]}, 32'd1);

        // Unsigned LEZ / LTZ / GEZ on the sign-bit pattern
        drive(1'b1, 32'h8000_0000, 32'd0, CMP_LEZ, 1'b0); tick();
        check("ulez_msb", s_o[0], 32'd0);
        drive(1'b1, 32'h8000_0000, 32'd0, CMP_LTZ, 1'b0); tick();
        check("ultz_msb", s_o[0], 32'd0);
        drive(1'b1, 32'h8000_0000, 32'd0, CMP_GEZ, 1'b0); tick();
        check("ugez_msb", s_o[0], 32'd1);
        drain(3);

        // Reserved mode
        saved = mcnt[0];
        drive(1'b1, $urandom, $urandom, CMP_RSV, 1'($urandom)); tick();
        check("rsv_s", s_o[0], 32'd0);
        check("rsv_zv", {30'b0, z[0], v[0]}, 32'd3);
        drive(1'b0, '0, '0, CMP_EQ, 1'b0); tick();
        check("rsv_zv2", {30'b0, z[1], v[1]}, 32'd3);
        tick();
        check("rsv_cnt", {28'b0, cnt_a}, saved);

        // Saturation of the 4-bit counter, then clear against a true handshake
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tmp = pick_op();
            drive(1'b1, tmp, tmp, CMP_EQ, 1'($urandom)); tick();
        end
        drive(1'b0, '0, '0, CMP_EQ, 1'b0); tick(); tick(); tick();
        check("sat_cnt_a", {28'b0, cnt_a}, 32'd15);
        check("sat_cnt_b", {16'b0, cnt_b}, 32'd20);
        drive(1'b1, 32'd7, 32'd7, CMP_EQ, 1'b0); tick();
        cnt_clr = 1'b1;
        drive(1'b1, 32'd9, 32'd9, CMP_EQ, 1'b0); tick();
        cnt_clr = 1'b0;
        check("clr_wins", {28'b0, cnt_a}, 32'd0);
        drain(4);

        // Two-stage LT stream with a 3-cycle stall in the middle
        for (int i = 0; i < 10; i++) begin
            la[i] = pick_op(); lb[i] = pick_op(); ls[i] = 1'($urandom);
        end
        begin
            int i = 0;
            int cyc = 0;
            while (i < 10 && cyc < 40) begin
                out_ready = !(cyc >= 5 && cyc < 8);
                drive(1'b1, la[i], lb[i], CMP_LT, ls[i]);
                tick();
                if (cyc == 0) check("lat2_early", {31'b0, ov[1]}, 32'd0);
                if (cyc == 1) check("lat2_first", {31'b0, ov[1]}, 32'd1);
                if (!out_ready) check("stall_in_ready", {31'b0, rdy[1]}, 32'd0);
                if (accd[1]) i++;
                cyc++;
            end
            check("stream_done", i, 32'd10);
        end
        drain(4);

        // Randomised traffic with back-pressure and occasional clears
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            drive(($urandom_range(0, 3) != 0), pick_op(), pick_op(),
                  3'($urandom_range(0, 7)), 1'($urandom));
            tick();
        end
        cnt_clr = 1'b0;
        drain(4);

        // Reset with beats in flight
        out_ready = 1'b1;
        drive(1'b1, 32'd1, 32'd1, CMP_EQ, 1'b0); tick();
        drive(1'b1, 32'd2, 32'd2, CMP_EQ, 1'b0); tick();
        drive(1'b0, '0, '0, CMP_EQ, 1'b0);
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", {30'b0, ov}, 32'd0);
        check("arst_cnt", {cnt_b, 12'b0, cnt_a}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_rst_in_ready", {30'b0, rdy}, 32'd3);
        drain(5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
